reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_CH, default 2, number of open-drain reset channels; legal range 1..16.
REQ-002 Parameter PULSE_CYCLES, default 16, minimum reset assertion length in clocks; legal range >= 1.
REQ-003 Parameter GAP_CYCLES, default 4, stagger in clocks between successive channel releases; legal range >= 1.
REQ-004 Parameter TICK_W, default 32, width of the run-time tick counter.
REQ-005 Parameter LIMIT, default 1000, run ticks before done; 0 means unlimited.
REQ-006 Port _C1  in  1  system clock; all state updates on its rising edge.
REQ-007 Port reset  in  1  synchronous, active-high reset.
REQ-008 Port req  in  1  restart request; sampled each clock; restarts the whole sequence.
REQ-009 Port hold  in  1  while high in ASSERT, freezes the pulse counter and extends reset.
REQ-010 Port rst_oe  out  N_CH  per-channel drive-low enable for an external open-drain _RST line; 1 = pull low.
REQ-011 Port busy  out  1  high in ASSERT or RELEASE.
REQ-012 Port ticks  out  TICK_W  clocks spent in RUN since the last release.
REQ-013 Port done  out  1  sticky; high in DONE.
REQ-014 Port done_pulse  out  1  single-cycle strobe on entry to DONE.

Function
REQ-015 The FSM SHALL have four states: ASSERT, RELEASE, RUN, DONE.
REQ-016 All outputs SHALL be registered; no combinational path from an input to an output.
REQ-017 In ASSERT, all rst_oe bits SHALL be 1; the pulse counter counts 0..PULSE_CYCLES-1 and advances only when hold=0.
REQ-018 When the pulse counter reaches PULSE_CYCLES-1 with hold=0, the FSM SHALL move to RELEASE and clear rst_oe[0] on the same edge.
REQ-019 In RELEASE, rst_oe[k] SHALL clear exactly GAP_CYCLES clocks after rst_oe[k-1]; channels release in ascending index only.
REQ-020 The edge that clears rst_oe[N_CH-1] SHALL enter RUN; with N_CH=1 this is the ASSERT exit edge and RELEASE is skipped.
REQ-021 With an uninterrupted sequence and hold=0, rst_oe[k] SHALL first read 0 PULSE_CYCLES + k*GAP_CYCLES clocks after the first edge sampling reset=0.
REQ-022 hold SHALL be ignored outside ASSERT.
REQ-023 In RUN, ticks SHALL increment by 1 per clock, starting on the first clock after RUN is entered.
REQ-024 If LIMIT != 0, the edge taking ticks from LIMIT-1 to LIMIT SHALL enter DONE, set done, and assert done_pulse for exactly that one cycle.
REQ-025 In DONE, ticks SHALL hold at LIMIT, rst_oe SHALL stay all 0, and done SHALL stay 1.
REQ-026 If LIMIT = 0, DONE SHALL never be entered and ticks SHALL wrap modulo 2^TICK_W.
REQ-027 req=1 in any state SHALL enter ASSERT on the next edge and take effect as follows:
- all rst_oe bits set to 1
- pulse counter set to 0
- ticks set to 0
- done set to 0
REQ-028 req=1 held high SHALL keep the block in ASSERT with the pulse counter at 0.
REQ-029 req=1 on the same edge that would release a channel or enter DONE SHALL take priority; that release or entry does not occur and no done_pulse is produced.
REQ-030 busy SHALL be 1 exactly when the registered state is ASSERT or RELEASE.

Reset
REQ-031 On a sampled reset=1, the block SHALL take these values on that edge:
- state ASSERT, pulse counter 0, gap counter 0
- rst_oe all 1, busy 1
- ticks 0, done 0, done_pulse 0
REQ-032 reset SHALL take priority over req and hold.
REQ-033 Reset asserted mid-sequence, in RUN or in DONE SHALL restart the sequence identically to power-up.

Verification
REQ-034 Defaults, reset high for 5 clocks then low, hold=0, req=0 -> expected response:
- rst_oe[0] low 16 clocks after reset release
- rst_oe[1] low at 20 clocks; busy falls at 20
- done and done_pulse at 1020; ticks=1000 thereafter
REQ-035 Defaults, hold=1 for 10 clocks starting 5 clocks after reset release -> rst_oe[0] low at 26 clocks, rst_oe[1] low at 30 clocks.
REQ-036 Defaults, req pulsed for 1 clock while ticks=500 -> expected response:
- next edge: rst_oe=2'b11, ticks=0, busy=1
- sequence repeats with the REQ-034 timing measured from the req edge
REQ-037 Defaults, req pulsed in the cycle before ticks would reach 1000 -> no done_pulse, done stays 0, ticks=0, rst_oe=2'b11.
REQ-038 N_CH=1, PULSE_CYCLES=1, LIMIT=0, TICK_W=4 -> expected response:
- rst_oe low 1 clock after reset release
- ticks wraps 15->0
- done never asserts
REQ-039 Defaults, reset reasserted during RELEASE (rst_oe=2'b10) -> rst_oe=2'b11, busy=1, ticks=0 on the next edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered open-drain reset generator with run-time tick counter.
//
// After reset (or a restart request) every channel's drive-low enable is asserted for at
// least PULSE_CYCLES clocks, then the channels are released one by one in ascending index
// order, GAP_CYCLES clocks apart. Once the last channel is released the block counts run
// ticks and, when LIMIT is non-zero, stops in a sticky DONE state after LIMIT ticks.
//
// Ports
//   _C1         in   system clock, rising edge
//   reset       in   synchronous active-high reset, highest priority
//   req         in   restart request, sampled every clock
//   hold        in   freezes the pulse counter while in ASSERT
//   rst_oe      out  per-channel drive-low enable (1 = pull the external reset line low)
//   busy        out  high in ASSERT or RELEASE
//   ticks       out  clocks spent in RUN since the last release
//   done        out  sticky, high in DONE
//   done_pulse  out  one-cycle strobe on entry to DONE
module reset_sequencer #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned PULSE_CYCLES = 16,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned TICK_W       = 32,
    parameter int unsigned LIMIT        = 1000
) (
    input  logic              _C1,
    input  logic              reset,
    input  logic              req,
    input  logic              hold,
    output logic [N_CH-1:0]   rst_oe,
    output logic              busy,
    output logic [TICK_W-1:0] ticks,
    output logic              done,
    output logic              done_pulse
);

    localparam int unsigned PulseW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PulseW-1:0] PulseLast = PulseW'(PULSE_CYCLES - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'(GAP_CYCLES - 1);

    // Channels are released by shifting zeros in from bit 0, so the vector holding only
    // its top bit means the next release is the final one.
    localparam logic [N_CH-1:0] OeOne  = N_CH'(1);
    localparam logic [N_CH-1:0] OeLast = OeOne << (N_CH - 1);

    localparam logic [TICK_W-1:0] TickLimit  = TICK_W'(LIMIT);
    localparam logic [TICK_W-1:0] TickPenult = TICK_W'(LIMIT - 1);

    typedef enum logic [1:0] {
        StAssert,
        StRelease,
        StRun,
        StDone
    } state_e;

    state_e              state_q;
    logic [PulseW-1:0]   pulse_q;
    logic [GapW-1:0]     gap_q;
    logic [N_CH-1:0]     rst_oe_q;
    logic                busy_q;
    logic [TICK_W-1:0]   ticks_q;
    logic                done_q;
    logic                done_pulse_q;

    always_ff @(posedge _C1) begin
        if (reset || req) begin
            // Reset and restart share one effect; a restart also pre-empts any release or
            // DONE entry that would otherwise happen on this edge.
            state_q      <= StAssert;
            pulse_q      <= '0;
            gap_q        <= '0;
            rst_oe_q     <= '1;
            busy_q       <= 1'b1;
            ticks_q      <= '0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            unique case (state_q)
                StAssert: begin
                    if (!hold) begin
                        if (pulse_q == PulseLast) begin
                            pulse_q  <= '0;
                            gap_q    <= '0;
                            rst_oe_q <= rst_oe_q << 1;
                            if (N_CH == 1) begin
                                state_q <= StRun;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= StRelease;
                            end
                        end else begin
                            pulse_q <= pulse_q + 1'b1;
                        end
                    end
                end
                StRelease: begin
                    if (gap_q == GapLast) begin
                        gap_q    <= '0;
                        rst_oe_q <= rst_oe_q << 1;
                        if (rst_oe_q == OeLast) begin
                            state_q <= StRun;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                StRun: begin
                    if ((LIMIT != 0) && (ticks_q == TickPenult)) begin
                        ticks_q      <= TickLimit;
                        state_q      <= StDone;
                        done_q       <= 1'b1;
                        done_pulse_q <= 1'b1;
                    end else begin
                        ticks_q <= ticks_q + 1'b1;
                    end
                end
                StDone: begin
                    // Terminal until reset or req.
                end
                default: begin
                    state_q <= StAssert;
                end
            endcase
        end
    end

    assign rst_oe     = rst_oe_q;
    assign busy       = busy_q;
    assign ticks      = ticks_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;

endmodule
